// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state/mode types and latency helper for the SPI master
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } spi_state_e;

    // Encoded as {cpol, cpha}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    // Cycles from the accepting clock edge to the done pulse
    function automatic int spi_latency(input int data_w, input int clk_div);
        return 1 + (2 * data_w + 1) * (clk_div / 2);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period divider producing sclk and its edge strobes
module spi_sclk_gen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic toggle_en_i,
    input  logic cpol_i,
    output logic sclk_o,
    output logic tick_o,
    output logic lead_edge_o,
    output logic trail_edge_o
);

    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DIV_W-1:0] div_q;
    logic             sclk_q;

    // Strobes are high in the cycle whose clock edge toggles sclk_q
    assign tick_o       = en_i && (div_q == DIV_W'(HALF - 1));
    assign lead_edge_o  = tick_o && toggle_en_i && (sclk_q == cpol_i);
    assign trail_edge_o = tick_o && toggle_en_i && (sclk_q != cpol_i);
    assign sclk_o       = sclk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!en_i) begin
            div_q  <= '0;
            sclk_q <= cpol_i;
        end else begin
            div_q <= tick_o ? '0 : div_q + 1'b1;
            if (tick_o && toggle_en_i) begin
                sclk_q <= ~sclk_q;
            end
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - SPI master with runtime CPOL/CPHA, full-duplex shift and ready/done handshake
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n
);

    localparam int HALF   = CLK_DIV / 2;
    localparam int EDGES  = 2 * DATA_W;
    localparam int EDGE_W = $clog2(EDGES + 1);

    spi_state_e        state_q;
    spi_mode_e         mode_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [EDGE_W-1:0] edge_q;
    logic              ready_q;
    logic              done_q;
    logic              mosi_q;
    logic              cs_n_q;

    logic gen_cpol;
    logic tick;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    // Idle sclk follows the live cpol input; during a transfer the latched mode rules
    assign gen_cpol = (state_q == IDLE) ? cpol : mode_q[1];

    spi_sclk_gen #(
        .HALF (HALF)
    ) u_sclk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (state_q != IDLE),
        .toggle_en_i  ((state_q == LEAD) || (state_q == SHIFT)),
        .cpol_i       (gen_cpol),
        .sclk_o       (sclk),
        .tick_o       (tick),
        .lead_edge_o  (lead_edge),
        .trail_edge_o (trail_edge)
    );

    // The final trailing edge of a cpha=0 transfer has no further bit to present
    assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
    assign shift_edge  = mode_q[0] ? lead_edge
                                   : (trail_edge && (edge_q != EDGE_W'(EDGES - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= MODE0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            edge_q    <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The done cycle itself never accepts a new request
                    if (start && ready_q && !done_q) begin
                        mode_q  <= spi_mode_e'({cpol, cpha});
                        rx_sh_q <= '0;
                        edge_q  <= '0;
                        ready_q <= 1'b0;
                        cs_n_q  <= 1'b0;
                        state_q <= LEAD;
                        if (cpha) begin
                            tx_sh_q <= tx_data;
                        end else begin
                            tx_sh_q <= drop_bit(tx_data);
                            mosi_q  <= head_bit(tx_data);
                        end
                    end
                end
                LEAD, SHIFT: begin
                    if (tick) begin
                        edge_q  <= edge_q + 1'b1;
                        state_q <= (edge_q == EDGE_W'(EDGES - 1)) ? TRAIL : SHIFT;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        cs_n_q    <= 1'b1;
                        mosi_q    <= 1'b0;
                        rx_data_q <= rx_sh_q;
                        done_q    <= 1'b1;
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (sample_edge) begin
                rx_sh_q <= (MSB_FIRST != 0) ? {rx_sh_q[DATA_W-2:0], miso}
                                            : {miso, rx_sh_q[DATA_W-1:1]};
            end
            if (shift_edge) begin
                mosi_q  <= head_bit(tx_sh_q);
                tx_sh_q <= drop_bit(tx_sh_q);
            end
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb/tb_spi_master_cfg.sv - directed and random checks of spi_master_cfg against a behavioural SPI slave
module tb_spi_master_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic       rst8_n, start8, cpol8, cpha8, miso8;
    logic       ready8, done8, sclk8, mosi8, cs8_n;
    logic [7:0] tx8, rx8;

    logic        rst16_n, start16, cpol16, cpha16;
    logic        ready16, done16, sclk16, mosi16, cs16_n;
    logic [15:0] tx16, rx16;

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1)) dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .cpol(cpol8), .cpha(cpha8),
        .tx_data(tx8), .miso(miso8), .ready(ready8), .done(done8), .rx_data(rx8),
        .sclk(sclk8), .mosi(mosi8), .cs_n(cs8_n)
    );

    spi_master_cfg #(.DATA_W(16), .CLK_DIV(8), .MSB_FIRST(0)) dut16 (
        .clk(clk), .rst_n(rst16_n), .start(start16), .cpol(cpol16), .cpha(cpha16),
        .tx_data(tx16), .miso(mosi16), .ready(ready16), .done(done16), .rx_data(rx16),
        .sclk(sclk16), .mosi(mosi16), .cs_n(cs16_n)
    );

    // Behavioural slave for the 8-bit master (MSB first)
    bit         xfer_cpol = 1'b0, xfer_cpha = 1'b0;
    logic       loop8 = 1'b0, slv_bit = 1'b0;
    logic [7:0] slv_word = '0, slv_rx = '0;
    int         edges8 = 0, rises8 = 0, shifts8 = 0, viol8 = 0, idx8 = 0;
    logic       prev_sclk8 = 1'b0, prev_mosi8 = 1'b0, prev_cs8_n = 1'b1;
    bit         edge_now8, lead8;

    assign miso8 = loop8 ? mosi8 : slv_bit;

    always @(negedge clk) begin
        if (!cs8_n && !prev_cs8_n) begin
            edge_now8 = (sclk8 !== prev_sclk8);
            lead8     = (prev_sclk8 === xfer_cpol);
            if (edge_now8) begin
                edges8++;
                if (sclk8 === 1'b1) rises8++;
                if (lead8 != xfer_cpha) begin
                    slv_rx = {slv_rx[6:0], mosi8};
                end else begin
                    shifts8++;
                    idx8 = xfer_cpha ? shifts8 - 1 : shifts8;
                    if (idx8 < 8) slv_bit = slv_word[7 - idx8];
                end
            end
            if (mosi8 !== prev_mosi8 && !(edge_now8 && lead8 == xfer_cpha)) viol8++;
        end
        prev_sclk8 = sclk8;
        prev_mosi8 = mosi8;
        prev_cs8_n = cs8_n;
    end

    // Sample-edge monitor for the 16-bit LSB-first master in loopback
    bit          x16_cpol = 1'b0, x16_cpha = 1'b0;
    logic [15:0] mon16 = '0;
    int          n16 = 0;
    logic        prev_sclk16 = 1'b0, prev_cs16_n = 1'b1;

    always @(negedge clk) begin
        if (!cs16_n && !prev_cs16_n && sclk16 !== prev_sclk16 &&
            ((prev_sclk16 === x16_cpol) != x16_cpha)) begin
            if (n16 < 16) mon16[n16] = mosi16;
            n16++;
        end
        prev_sclk16 = sclk16;
        prev_cs16_n = cs16_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic xfer8(input logic [1:0] mode, input logic [7:0] tx, input logic [7:0] sw,
                         input logic lb, input bit busy);
        int n;
        @(negedge clk);
        xfer_cpol = mode[1]; xfer_cpha = mode[0];
        cpol8 = mode[1]; cpha8 = mode[0]; tx8 = tx;
        slv_word = sw; slv_bit = sw[7]; loop8 = lb;
        slv_rx = '0; edges8 = 0; rises8 = 0; shifts8 = 0; viol8 = 0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("lead_cs_n", cs8_n, 1'b0);
        check("lead_ready", ready8, 1'b0);
        cpol8 = 1'($urandom); cpha8 = 1'($urandom); tx8 = 8'($urandom);
        n = 1;
        while (done8 !== 1'b1 && n < 200) begin
            start8 = busy && (n == 5);
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        check("done_pulse", done8, 1'b1);
        check("latency8", n, 35);
        check("rx_data8", rx8, lb ? tx : sw);
        check("slave_rx8", slv_rx, tx);
        check("edge_count", edges8, 16);
        check("rise_count", rises8, 8);
        check("mosi_edge_rule", viol8, 0);
        check("done_cs_n", cs8_n, 1'b1);
        check("done_ready", ready8, 1'b1);
        check("done_mosi", mosi8, 1'b0);
        check("idle_sclk", sclk8, mode[1]);
        cpol8 = mode[1]; cpha8 = mode[0]; tx8 = tx;
        if (busy) begin
            start8 = 1'b1;
            @(negedge clk);
            check("done_cycle_start_ignored", cs8_n, 1'b1);
            check("done_one_cycle", done8, 1'b0);
            check("rx_held", rx8, lb ? tx : sw);
            @(negedge clk);
            start8 = 1'b0;
            check("accept_after_done", cs8_n, 1'b0);
            n = 1;
            while (done8 !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("second_latency", n, 35);
        end
    endtask

    task automatic xfer16(input logic [1:0] mode, input logic [15:0] tx);
        int n;
        @(negedge clk);
        x16_cpol = mode[1]; x16_cpha = mode[0];
        cpol16 = mode[1]; cpha16 = mode[0]; tx16 = tx;
        mon16 = '0; n16 = 0;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        check("lead16_cs_n", cs16_n, 1'b0);
        tx16 = 16'($urandom);
        n = 1;
        while (done16 !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("done16", done16, 1'b1);
        check("latency16", n, 133);
        check("rx_data16", rx16, tx);
        check("lsb_first_order", mon16, tx);
        check("sample_count16", n16, 16);
        check("idle_sclk16", sclk16, mode[1]);
    endtask

    initial begin
        int dones;
        rst8_n = 1'b0; rst16_n = 1'b0;
        start8 = 1'b0; cpol8 = 1'b1; cpha8 = 1'b0; tx8 = '0;
        start16 = 1'b0; cpol16 = 1'b0; cpha16 = 1'b0; tx16 = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready8, 1'b1);
        check("rst_done", done8, 1'b0);
        check("rst_rx", rx8, 8'h00);
        check("rst_sclk", sclk8, 1'b0);
        check("rst_mosi", mosi8, 1'b0);
        check("rst_cs_n", cs8_n, 1'b1);
        check("rst16_rx", rx16, 16'h0000);
        rst8_n = 1'b1; rst16_n = 1'b1;
        cpol8 = 1'b0;
        @(negedge clk);

        xfer8(2'b00, 8'hA5, 8'h00, 1'b1, 1'b0);
        xfer8(2'b11, 8'h3C, 8'hC3, 1'b0, 1'b0);
        xfer8(2'b01, 8'h81, 8'($urandom), 1'b0, 1'b0);
        xfer8(2'b10, 8'h81, 8'($urandom), 1'b0, 1'b0);
        xfer8(2'b00, 8'h5A, 8'h96, 1'b0, 1'b1);

        @(negedge clk);
        cpol8 = 1'b1;
        @(negedge clk);
        check("idle_track_hi", sclk8, 1'b1);
        cpol8 = 1'b0;
        @(negedge clk);
        check("idle_track_lo", sclk8, 1'b0);

        // Abort a mode 3 transfer mid-flight
        xfer_cpol = 1'b1; xfer_cpha = 1'b1;
        cpol8 = 1'b1; cpha8 = 1'b1; tx8 = 8'hFF; loop8 = 1'b1;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_pre_sclk", sclk8, 1'b1);
        check("abort_pre_mosi", mosi8, 1'b1);
        rst8_n = 1'b0;
        #1;
        check("abort_cs_n", cs8_n, 1'b1);
        check("abort_sclk", sclk8, 1'b0);
        check("abort_mosi", mosi8, 1'b0);
        check("abort_ready", ready8, 1'b1);
        check("abort_rx", rx8, 8'h00);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        rst8_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_rx_after", rx8, 8'h00);

        xfer16(2'b00, 16'h1234);

        for (int i = 0; i < 8; i++) begin
            xfer8(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            xfer16(2'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
